// File: rtl/grant_decoder_3to8_pkg.sv
// Shared encodings and widths for the 3-to-8 grant decoder.
package grant_pkg;

  localparam int IDX_W = 3;
  localparam int GNT_W = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

endpackage

// File: rtl/grant_decoder_3to8_dec.sv
// Combinational index-to-one-hot decoder feeding the grant register.
module dec_3to8
  import grant_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [GNT_W-1:0] onehot
);

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/grant_decoder_3to8.sv
// Registered 3-to-8 grant decoder: valid/ready index intake, one-hot grant
// held until release or HOLD_MAX, then a GAP-cycle idle window.
module grant_decoder_3to8
  import grant_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int GAP      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IDX_W-1:0] in_idx,
  // "release" is a reserved word, hence the suffix
  input  logic             release_req,
  output logic [GNT_W-1:0] y,
  output logic             busy,
  output logic             timeout
);

  localparam int CNT_MAX = (HOLD_MAX > GAP) ? HOLD_MAX : GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] GAP_C  = CNT_W'(GAP);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  // With GAP=0 the grant returns straight to IDLE.
  localparam logic [1:0]       END_ST  = (GAP > 0) ? ST_GAP : ST_IDLE;
  localparam logic [CNT_W-1:0] END_CNT = (GAP > 0) ? ONE_C : '0;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [GNT_W-1:0] dec_y;

  dec_3to8 u_dec (
    .idx    (in_idx),
    .onehot (dec_y)
  );

  assign in_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      y       <= '0;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            y     <= dec_y;
            cnt   <= ONE_C;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Release wins over the hold limit in the final cycle.
          if (release_req || (cnt == HOLD_C)) begin
            y       <= '0;
            cnt     <= END_CNT;
            state   <= END_ST;
            timeout <= !release_req;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        ST_GAP: begin
          if (cnt >= GAP_C) begin
            cnt   <= '0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + ONE_C;
          end
        end
        default: begin
          y     <= '0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_decoder_3to8.sv
// Directed self-checking bench: default-parameter instance plus a
// HOLD_MAX=1/GAP=0 instance for back-to-back grants.
module tb_grant_decoder_3to8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;

  logic       valid_a = 1'b0;
  logic [2:0] idx_a = 3'd0;
  logic       rel_a = 1'b0;
  logic       ready_a;
  logic [7:0] y_a;
  logic       busy_a;
  logic       to_a;

  logic       valid_b = 1'b0;
  logic [2:0] idx_b = 3'd0;
  logic       rel_b = 1'b0;
  logic       ready_b;
  logic [7:0] y_b;
  logic       busy_b;
  logic       to_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  grant_decoder_3to8 #(.HOLD_MAX(8), .GAP(1)) dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (valid_a),
    .in_ready    (ready_a),
    .in_idx      (idx_a),
    .release_req (rel_a),
    .y           (y_a),
    .busy        (busy_a),
    .timeout     (to_a)
  );

  grant_decoder_3to8 #(.HOLD_MAX(1), .GAP(0)) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (valid_b),
    .in_ready    (ready_b),
    .in_idx      (idx_b),
    .release_req (rel_b),
    .y           (y_b),
    .busy        (busy_b),
    .timeout     (to_b)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_y;

    // Power-on reset
    #2 rst_n = 1'b0;
    #1;
    check("por_y", y_a, 8'h00);
    check("por_busy", {7'd0, busy_a}, 8'h00);
    check("por_timeout", {7'd0, to_a}, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("por_ready", {7'd0, ready_a}, 8'h01);

    // Release outside GRANT is ignored
    rel_a = 1'b1;
    tick();
    check("idle_rel_y", y_a, 8'h00);
    check("idle_rel_busy", {7'd0, busy_a}, 8'h00);
    rel_a = 1'b0;

    // idx 3, release in grant cycle 4
    idx_a = 3'd3; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    check("t2_ready_in_grant", {7'd0, ready_a}, 8'h00);
    check("t2_busy_in_grant", {7'd0, busy_a}, 8'h01);
    for (int n = 1; n <= 4; n++) begin
      check($sformatf("t2_y_c%0d", n), y_a, 8'h08);
      check($sformatf("t2_to_c%0d", n), {7'd0, to_a}, 8'h00);
      if (n == 4) rel_a = 1'b1;
      tick();
    end
    rel_a = 1'b0;
    check("t2_y_end", y_a, 8'h00);
    check("t2_to_end", {7'd0, to_a}, 8'h00);
    check("t2_ready_gap", {7'd0, ready_a}, 8'h00);
    check("t2_busy_gap", {7'd0, busy_a}, 8'h01);
    tick();
    check("t2_ready_idle", {7'd0, ready_a}, 8'h01);
    check("t2_busy_idle", {7'd0, busy_a}, 8'h00);
    check("t2_to_idle", {7'd0, to_a}, 8'h00);

    // idx 7, no release: HOLD_MAX timeout
    idx_a = 3'd7; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      check($sformatf("t3_y_c%0d", n), y_a, 8'h80);
      check($sformatf("t3_to_c%0d", n), {7'd0, to_a}, 8'h00);
      tick();
    end
    check("t3_y_end", y_a, 8'h00);
    check("t3_to_pulse", {7'd0, to_a}, 8'h01);
    check("t3_ready_gap", {7'd0, ready_a}, 8'h00);
    idx_a = 3'd2; valid_a = 1'b1;
    tick();
    check("t3_to_drop", {7'd0, to_a}, 8'h00);
    check("t3_gap_no_accept", y_a, 8'h00);
    check("t3_ready_idle", {7'd0, ready_a}, 8'h01);
    tick();
    valid_a = 1'b0;
    check("t3_next_accept", y_a, 8'h04);
    rel_a = 1'b1;
    tick();
    rel_a = 1'b0;
    check("t3_rel_y", y_a, 8'h00);
    tick();

    // idx 7, release in the final hold cycle
    idx_a = 3'd7; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      check($sformatf("t4_y_c%0d", n), y_a, 8'h80);
      if (n == 8) rel_a = 1'b1;
      tick();
    end
    rel_a = 1'b0;
    check("t4_y_end", y_a, 8'h00);
    check("t4_no_timeout", {7'd0, to_a}, 8'h00);
    tick();
    check("t4_no_timeout_late", {7'd0, to_a}, 8'h00);
    check("t4_ready", {7'd0, ready_a}, 8'h01);

    // in_valid held with a new index during GRANT and GAP
    idx_a = 3'd5; valid_a = 1'b1;
    tick();
    idx_a = 3'd1;
    check("t5_y_first", y_a, 8'h20);
    tick();
    check("t5_y_held", y_a, 8'h20);
    rel_a = 1'b1;
    tick();
    rel_a = 1'b0;
    check("t5_gap_y", y_a, 8'h00);
    tick();
    check("t5_idle_y", y_a, 8'h00);
    check("t5_idle_ready", {7'd0, ready_a}, 8'h01);
    tick();
    valid_a = 1'b0;
    check("t5_new_accept", y_a, 8'h02);
    rel_a = 1'b1;
    tick();
    rel_a = 1'b0;
    tick();

    // Asynchronous reset mid-GRANT
    idx_a = 3'd5; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    tick();
    check("t1_pre_reset_y", y_a, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    check("t1_reset_y", y_a, 8'h00);
    check("t1_reset_busy", {7'd0, busy_a}, 8'h00);
    check("t1_reset_to", {7'd0, to_a}, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    check("t1_post_ready", {7'd0, ready_a}, 8'h01);
    check("t1_post_y", y_a, 8'h00);
    check("t1_post_to", {7'd0, to_a}, 8'h00);

    // HOLD_MAX=1, GAP=0: back-to-back walk across all indices
    valid_b = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idx_b = 3'(i);
      exp_y = 8'h01 << i;
      check($sformatf("t6_ready_pre_%0d", i), {7'd0, ready_b}, 8'h01);
      tick();
      check($sformatf("t6_y_%0d", i), y_b, exp_y);
      check($sformatf("t6_ready_grant_%0d", i), {7'd0, ready_b}, 8'h00);
      check($sformatf("t6_to_grant_%0d", i), {7'd0, to_b}, 8'h00);
      tick();
      check($sformatf("t6_y_off_%0d", i), y_b, 8'h00);
      check($sformatf("t6_to_pulse_%0d", i), {7'd0, to_b}, 8'h01);
    end
    valid_b = 1'b0;
    tick();
    check("t6_final_ready", {7'd0, ready_b}, 8'h01);
    check("t6_final_to", {7'd0, to_b}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
